move_timer: RTL and testbench

Per-move countdown controller for the Go game clock. It runs on clk_200Hz and consumes the clk_1Hz and clk_2Hz ticks from the clock generator. It drives back the clk_1Hz_rst request so that every move starts on a freshly phased one-second boundary. It outputs the acting player, remaining seconds in BCD for the display mux, a timeout pulse, and a 2 Hz warning blink.

---
 rtl/move_timer.sv | 138 +++++++++++++
 tb/tb_move_timer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/move_timer.sv
// Per-move BCD countdown for the Go game clock; re-phases the 1 Hz/2 Hz dividers on every new move.
// Optional pause input is enabled by defining MOVE_TIMER_PAUSE_EN.
module move_timer #(
  parameter int unsigned MOVE_SECONDS = 30,
  parameter int unsigned WARN_SECONDS = 5
) (
  input  logic       clk_200Hz,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       move_done,
`ifdef MOVE_TIMER_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       clk_1Hz,
  input  logic       clk_2Hz,
  output logic       clk_1Hz_rst,
  output logic       player,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       timeout,
  output logic       warn
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, EXPIRED} state_t;

  localparam logic [3:0] LOAD_TENS  = 4'(MOVE_SECONDS / 10);
  localparam logic [3:0] LOAD_ONES  = 4'(MOVE_SECONDS % 10);
  localparam logic [6:0] WARN_LIMIT = 7'(WARN_SECONDS);

  state_t     state, state_next;
  logic [3:0] tens_next, ones_next;
  logic       player_next, timeout_next;
  logic       clk_1Hz_q, tick;
  logic [6:0] count_bin;
  logic       paused, resume;

  assign tick      = clk_1Hz & ~clk_1Hz_q;
  assign count_bin = ({3'b000, sec_tens} * 7'd10) + {3'b000, sec_ones};

`ifdef MOVE_TIMER_PAUSE_EN
  logic pause_q;

  always_ff @(posedge clk_200Hz or negedge rst_n) begin
    if (!rst_n) pause_q <= 1'b0;
    else        pause_q <= pause;
  end

  always_comb begin
    paused = (state == RUN) && pause;
    resume = (state == RUN) && pause_q && !pause;
  end
`else
  always_comb begin
    paused = 1'b0;
    resume = 1'b0;
  end
`endif

  always_ff @(posedge clk_200Hz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The count is loaded on the command edge, not in SYNC, so a pause release can
  // re-phase the dividers through SYNC while keeping the remaining time.
  always_comb begin
    state_next   = state;
    tens_next    = sec_tens;
    ones_next    = sec_ones;
    player_next  = player;
    timeout_next = 1'b0;
    if (stop) begin
      state_next = IDLE;
      tens_next  = '0;
      ones_next  = '0;
    end else if (start) begin
      state_next  = SYNC;
      player_next = 1'b0;
      tens_next   = LOAD_TENS;
      ones_next   = LOAD_ONES;
    end else if (move_done && (state == RUN || state == EXPIRED)) begin
      state_next  = SYNC;
      player_next = ~player;
      tens_next   = LOAD_TENS;
      ones_next   = LOAD_ONES;
    end else if (resume) begin
      state_next = SYNC;
    end else begin
      case (state)
        SYNC: state_next = RUN;
        RUN: begin
          if (tick && !paused && count_bin != '0) begin
            if (sec_ones == 4'd0) begin
              ones_next = 4'd9;
              tens_next = sec_tens - 4'd1;
            end else begin
              ones_next = sec_ones - 4'd1;
            end
            if (sec_tens == 4'd0 && sec_ones == 4'd1) begin
              state_next   = EXPIRED;
              timeout_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_200Hz or negedge rst_n) begin
    if (!rst_n) begin
      sec_tens  <= '0;
      sec_ones  <= '0;
      player    <= 1'b0;
      timeout   <= 1'b0;
      clk_1Hz_q <= 1'b0;
    end else begin
      sec_tens  <= tens_next;
      sec_ones  <= ones_next;
      player    <= player_next;
      timeout   <= timeout_next;
      clk_1Hz_q <= (state == SYNC) ? 1'b0 : clk_1Hz;
    end
  end

  always_comb begin
    running     = (state == RUN);
    clk_1Hz_rst = (state == SYNC);
    case (state)
      RUN:     warn = clk_2Hz && !paused && (count_bin <= WARN_LIMIT) && (count_bin != '0);
      EXPIRED: warn = 1'b1;
      default: warn = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_move_timer.sv
// Self-checking bench for move_timer: directed scenarios plus random pulses against a
// remaining-seconds reference model; clk_1Hz is held low after each divider re-phase request.
module tb_move_timer;

  localparam int MS = 30;
  localparam int WS = 5;
  localparam int M_IDLE = 0, M_SYNC = 1, M_RUN = 2, M_EXP = 3;
`ifdef MOVE_TIMER_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk_200Hz = 1'b0;
  logic       rst_n, start, stop, move_done, clk_1Hz, clk_2Hz;
  logic       clk_1Hz_rst, player, running, timeout, warn;
  logic [3:0] sec_tens, sec_ones;
`ifdef MOVE_TIMER_PAUSE_EN
  logic       pause;
`endif

  int errors = 0;
  int checks = 0;

  // reference model
  int mode, rem, hold;
  bit pl, exp_to, prev_c1, pause_prev;

  always #5 clk_200Hz = ~clk_200Hz;

  move_timer #(.MOVE_SECONDS(MS), .WARN_SECONDS(WS)) dut (
    .clk_200Hz  (clk_200Hz),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .move_done  (move_done),
`ifdef MOVE_TIMER_PAUSE_EN
    .pause      (pause),
`endif
    .clk_1Hz    (clk_1Hz),
    .clk_2Hz    (clk_2Hz),
    .clk_1Hz_rst(clk_1Hz_rst),
    .player     (player),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .running    (running),
    .timeout    (timeout),
    .warn       (warn)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE; rem = 0; pl = 1'b0; exp_to = 1'b0;
    prev_c1 = 1'b0; pause_prev = 1'b0; hold = 0;
  endtask

  task automatic model_update(input bit st, input bit sp, input bit md, input bit rise, input bit ps);
    exp_to = 1'b0;
    if (sp) begin
      mode = M_IDLE; rem = 0;
    end else if (st) begin
      pl = 1'b0; rem = MS; mode = M_SYNC;
    end else if (md && (mode == M_RUN || mode == M_EXP)) begin
      pl = ~pl; rem = MS; mode = M_SYNC;
    end else if (mode == M_SYNC) begin
      mode = M_RUN;
    end else if (mode == M_RUN && pause_prev && !ps) begin
      mode = M_SYNC;
    end else if (mode == M_RUN && !ps && rise && rem > 0) begin
      rem = rem - 1;
      if (rem == 0) begin
        mode = M_EXP; exp_to = 1'b1;
      end
    end
    pause_prev = ps;
    if (mode == M_SYNC) hold = 2;
  endtask

  task automatic check_all(input bit c2, input bit ps);
    bit w;
    w = (mode == M_EXP) || (mode == M_RUN && c2 && !ps && rem <= WS && rem != 0);
    chk("running",     {7'd0, running},     {7'd0, mode == M_RUN});
    chk("clk_1Hz_rst", {7'd0, clk_1Hz_rst}, {7'd0, mode == M_SYNC});
    chk("player",      {7'd0, player},      {7'd0, pl});
    chk("sec_tens",    {4'd0, sec_tens},    8'(rem / 10));
    chk("sec_ones",    {4'd0, sec_ones},    8'(rem % 10));
    chk("timeout",     {7'd0, timeout},     {7'd0, exp_to});
    chk("warn",        {7'd0, warn},        {7'd0, w});
  endtask

  task automatic step(input bit st, input bit sp, input bit md, input bit c1, input bit ps_in);
    bit c2, ps;
    ps = ps_in & PAUSE_EN;
    if (hold > 0) begin
      c1 = 1'b0; hold--;
    end
    c2 = 1'($urandom_range(0, 1));
    start = st; stop = sp; move_done = md; clk_1Hz = c1; clk_2Hz = c2;
`ifdef MOVE_TIMER_PAUSE_EN
    pause = ps;
`endif
    @(posedge clk_200Hz);
    model_update(st, sp, md, c1 && !prev_c1, ps);
    prev_c1 = c1;
    @(negedge clk_200Hz);
    check_all(c2, ps);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic rise_n(input int n, input bit ps);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 1, ps);
      step(0, 0, 0, 0, ps);
    end
  endtask

  initial begin
    bit c1r, psr;
    rst_n = 1'b0; start = 0; stop = 0; move_done = 0; clk_1Hz = 0; clk_2Hz = 0;
`ifdef MOVE_TIMER_PAUSE_EN
    pause = 0;
`endif
    model_reset();
    #3;
    check_all(1'b0, 1'b0);
    repeat (3) @(negedge clk_200Hz);
    rst_n = 1'b1;
    idle(3);
    chk("idle_count", {sec_tens, sec_ones}, 8'h00);

    // start: one SYNC cycle, then RUN at 30
    step(1, 0, 0, 0, 0);
    chk("sync_pulse", {7'd0, clk_1Hz_rst}, 8'd1);
    idle(2);
    chk("start_count", {sec_tens, sec_ones}, 8'h30);
    chk("start_run", {7'd0, running}, 8'd1);

    rise_n(10, 0);
    chk("count20", {sec_tens, sec_ones}, 8'h20);
    rise_n(1, 0);
    chk("borrow19", {sec_tens, sec_ones}, 8'h19);
    for (int i = 0; i < 100; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("held_high18", {sec_tens, sec_ones}, 8'h18);

    // move_done colliding with a tick at 12
    rise_n(6, 0);
    chk("count12", {sec_tens, sec_ones}, 8'h12);
    step(0, 0, 1, 1, 0);
    chk("collide_reload", {sec_tens, sec_ones}, 8'h30);
    chk("collide_player", {7'd0, player}, 8'd1);
    step(0, 0, 0, 0, 0);
    chk("collide_sync_done", {7'd0, clk_1Hz_rst}, 8'd0);
    idle(1);

    // run to expiry
    rise_n(29, 0);
    chk("count01", {sec_tens, sec_ones}, 8'h01);
    step(0, 0, 0, 1, 0);
    chk("timeout_pulse", {7'd0, timeout}, 8'd1);
    step(0, 0, 0, 0, 0);
    chk("timeout_clear", {7'd0, timeout}, 8'd0);
    chk("expired_warn", {7'd0, warn}, 8'd1);
    rise_n(3, 0);
    chk("expired_hold", {sec_tens, sec_ones}, 8'h00);

    // move_done from EXPIRED, count to 07, then asynchronous reset
    step(0, 0, 1, 0, 0);
    idle(2);
    chk("exp_reload_player", {7'd0, player}, 8'd0);
    rise_n(23, 0);
    chk("count07", {sec_tens, sec_ones}, 8'h07);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(clk_2Hz, 1'b0);
    @(negedge clk_200Hz);
    rst_n = 1'b1;
    rise_n(5, 0);
    chk("post_reset_idle", {sec_tens, sec_ones}, 8'h00);

    // stop mid-run keeps player
    step(1, 0, 0, 0, 0);
    idle(2);
    rise_n(2, 0);
    step(0, 0, 1, 0, 0);
    idle(2);
    step(0, 1, 0, 0, 0);
    chk("stop_count", {sec_tens, sec_ones}, 8'h00);
    chk("stop_player", {7'd0, player}, 8'd1);

`ifdef MOVE_TIMER_PAUSE_EN
    step(1, 0, 0, 0, 0);
    idle(2);
    rise_n(15, 0);
    chk("pause_count15", {sec_tens, sec_ones}, 8'h15);
    rise_n(5, 1);
    chk("paused_hold15", {sec_tens, sec_ones}, 8'h15);
    step(0, 0, 0, 0, 0);
    chk("resume_sync", {7'd0, clk_1Hz_rst}, 8'd1);
    idle(2);
    rise_n(1, 0);
    chk("resume_count14", {sec_tens, sec_ones}, 8'h14);
`endif

    // random pulses and clk_1Hz activity
    c1r = 1'b0; psr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) c1r = ~c1r;
      if ($urandom_range(0, 49) == 0) psr = ~psr;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0,
           $urandom_range(0, 59) == 0, c1r, psr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
